// File: rtl/stream_demux_1_to_2.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_1_to_2
//  Description : Routes one valid/ready stream to one of two outputs, chosen
//                per beat by s_sel. Each output has a 2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_to_2 #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sel,
    output logic                  m0_valid,
    input  logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m1_valid,
    input  logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_data,
    output logic [CNT_WIDTH-1:0]  m0_count,
    output logic [CNT_WIDTH-1:0]  m1_count
);

    localparam logic [1:0] C_OCC_FULL  = 2'd2;
    localparam logic [1:0] C_OCC_EMPTY = 2'd0;

    logic [1:0]            w_occ     [2];
    logic                  w_m_valid [2];
    logic [DATA_WIDTH-1:0] w_m_data  [2];
    logic [CNT_WIDTH-1:0]  w_m_count [2];
    logic [1:0]            w_m_ready;

    assign w_m_ready = {m1_ready, m0_ready};

    // Ready depends only on registered occupancy, never on the consumer side.
    assign s_ready = (w_occ[s_sel] != C_OCC_FULL);

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_ch
            logic [DATA_WIDTH-1:0] r_mem [2];
            logic                  r_wptr;
            logic                  r_rptr;
            logic [1:0]            r_occ;
            logic [CNT_WIDTH-1:0]  r_count;
            logic                  w_push;
            logic                  w_pop;

            assign w_push = s_valid && s_ready && (s_sel == 1'(k));
            assign w_pop  = (r_occ != C_OCC_EMPTY) && w_m_ready[k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wptr   <= 1'b0;
                    r_rptr   <= 1'b0;
                    r_occ    <= C_OCC_EMPTY;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wptr] <= s_data;
                        r_wptr        <= ~r_wptr;
                    end
                    if (w_pop) begin
                        r_rptr  <= ~r_rptr;
                        r_count <= r_count + 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_occ <= r_occ + 2'd1;
                        2'b01:   r_occ <= r_occ - 2'd1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert (!(w_push && (r_occ == C_OCC_FULL)));
                    assert (!(w_pop && (r_occ == C_OCC_EMPTY)));
                end
            end

            assign w_occ[k]     = r_occ;
            assign w_m_valid[k] = (r_occ != C_OCC_EMPTY);
            assign w_m_data[k]  = r_mem[r_rptr];
            assign w_m_count[k] = r_count;
        end
    endgenerate

    assign m0_valid = w_m_valid[0];
    assign m1_valid = w_m_valid[1];
    assign m0_data  = w_m_data[0];
    assign m1_data  = w_m_data[1];
    assign m0_count = w_m_count[0];
    assign m1_count = w_m_count[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_to_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux_1_to_2
//  Description : Scoreboard-based self-checking bench for stream_demux_1_to_2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_to_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sel;
    logic       m0_valid;
    logic       m0_ready;
    logic [7:0] m0_data;
    logic       m1_valid;
    logic       m1_ready;
    logic [7:0] m1_data;
    logic [7:0] m0_count;
    logic [7:0] m1_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] exp_cnt0;
    logic [7:0] exp_cnt1;

    stream_demux_1_to_2 #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_data  (m0_data),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_data  (m1_data),
        .m0_count (m0_count),
        .m1_count (m1_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: the queues mirror each FIFO's contents between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            exp_cnt0 = '0;
            exp_cnt1 = '0;
        end else begin
            checks++;
            if (m0_valid !== (q0.size() != 0)) begin
                errors++;
                $display("FAIL sb_m0_valid got %0b want %0b", m0_valid, q0.size() != 0);
            end
            checks++;
            if (m1_valid !== (q1.size() != 0)) begin
                errors++;
                $display("FAIL sb_m1_valid got %0b want %0b", m1_valid, q1.size() != 0);
            end
            if (s_valid) begin
                checks++;
                if (s_ready !== ((s_sel ? q1.size() : q0.size()) != 2)) begin
                    errors++;
                    $display("FAIL sb_s_ready got %0b sel %0b occ0 %0d occ1 %0d",
                             s_ready, s_sel, q0.size(), q1.size());
                end
            end
            if (q0.size() != 0) begin
                checks++;
                if (m0_data !== q0[0]) begin
                    errors++;
                    $display("FAIL sb_m0_data got %02h want %02h", m0_data, q0[0]);
                end
            end
            if (q1.size() != 0) begin
                checks++;
                if (m1_data !== q1[0]) begin
                    errors++;
                    $display("FAIL sb_m1_data got %02h want %02h", m1_data, q1[0]);
                end
            end
            checks++;
            if (m0_count !== exp_cnt0) begin
                errors++;
                $display("FAIL sb_m0_count got %0d want %0d", m0_count, exp_cnt0);
            end
            checks++;
            if (m1_count !== exp_cnt1) begin
                errors++;
                $display("FAIL sb_m1_count got %0d want %0d", m1_count, exp_cnt1);
            end
            if (m0_valid && m0_ready) begin
                if (q0.size() != 0) void'(q0.pop_front());
                exp_cnt0 = exp_cnt0 + 8'd1;
            end
            if (m1_valid && m1_ready) begin
                if (q1.size() != 0) void'(q1.pop_front());
                exp_cnt1 = exp_cnt1 + 8'd1;
            end
            if (s_valid && s_ready) begin
                if (s_sel) q1.push_back(s_data);
                else       q0.push_back(s_data);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic sel);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sel   = sel;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout got ready %0b want 1 data %02h", s_ready, d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_sel    = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        #2;
        checks++;
        if ({m0_valid, m1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid got %b want 00", {m0_valid, m1_valid});
        end
        checks++;
        if ({m0_count, m1_count, m0_data, m1_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {m0_count, m1_count, m0_data, m1_data});
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready got %0b want 1", s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_routing;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        send(8'hA5, 1'b0);
        checks++;
        if (m0_valid !== 1'b1 || m0_data !== 8'hA5) begin
            errors++;
            $display("FAIL route_m0 got v%0b %02h want v1 a5", m0_valid, m0_data);
        end
        send(8'h3C, 1'b1);
        checks++;
        if (m1_valid !== 1'b1 || m1_data !== 8'h3C || m0_valid !== 1'b0) begin
            errors++;
            $display("FAIL route_m1 got v%0b %02h m0v %0b want v1 3c m0v 0",
                     m1_valid, m1_data, m0_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m0_count !== 8'd1 || m1_count !== 8'd1) begin
            errors++;
            $display("FAIL route_counts got %0d %0d want 1 1", m0_count, m1_count);
        end
    endtask

    task automatic test_full_hol;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        s_valid = 1'b1;
        s_sel   = 1'b0;
        s_data  = 8'h33;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL hol_full got %0b want 0", s_ready);
        end
        m0_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL hol_no_bypass got %0b want 0", s_ready);
        end
        s_sel = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL hol_other_sel got %0b want 1", s_ready);
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m0_valid !== 1'b0 || m0_count !== 8'd3) begin
            errors++;
            $display("FAIL hol_drain got v%0b cnt %0d want v0 cnt 3", m0_valid, m0_count);
        end
    endtask

    task automatic test_push_pop;
        m0_ready = 1'b0;
        send(8'h55, 1'b0);
        m0_ready = 1'b1;
        send(8'h44, 1'b0);
        checks++;
        if (m0_valid !== 1'b1 || m0_data !== 8'h44) begin
            errors++;
            $display("FAIL pushpop_head got v%0b %02h want v1 44", m0_valid, m0_data);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m0_valid !== 1'b0 || m0_count !== 8'd5) begin
            errors++;
            $display("FAIL pushpop_drain got v%0b cnt %0d want v0 cnt 5", m0_valid, m0_count);
        end
    endtask

    task automatic test_reset_mid;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        s_sel = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({m0_valid, m1_valid} !== 2'b00 || {m0_count, m1_count} !== 16'h0) begin
            errors++;
            $display("FAIL midreset got v%b cnt %0d %0d want v00 cnt 0 0",
                     {m0_valid, m1_valid}, m0_count, m1_count);
        end
        checks++;
        if (s_ready !== 1'b1 || m0_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_fifo got rdy %0b data %02h want rdy 1 data 00", s_ready, m0_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_counter_wrap;
        m1_ready = 1'b1;
        for (int i = 0; i < 257; i++) send(8'(i), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m1_count !== 8'd1 || m0_count !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap got %0d %0d want 1 0", m1_count, m0_count);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 10000; c++) begin
            s_valid  = 1'($urandom_range(0, 1));
            s_sel    = 1'($urandom_range(0, 1));
            s_data   = 8'($urandom);
            m0_ready = ($urandom_range(0, 3) != 0);
            m1_ready = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b0;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got q %0d %0d v %0b%0b want q 0 0 v 00",
                     q0.size(), q1.size(), m0_valid, m1_valid);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full_hol();
        test_push_pop();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
